// File: rtl/neuron_mac_seq.sv
// Time-multiplexed neuron: one signed MAC per cycle, bias add, saturation,
// then either a sigmoid LUT lookup (registered ROM) or a linear pass-through.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE; out_valid is high only in OUT, and y/sat
// stay stable until the out_valid && out_ready edge. Both flags are registered.
module neuron_mac_seq #(
  parameter int N_IN      = 13,
  parameter int DW        = 17,
  parameter int FRAC      = 8,
  parameter int ADDR_W    = 11,
  parameter int LUT_SHIFT = 4,
  parameter int LUT_LAT   = 1,
  parameter int ACT_MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW*N_IN-1:0]   x,
  input  logic [DW*N_IN-1:0]   w,
  input  logic [DW-1:0]        bias,
  output logic [ADDR_W-1:0]    lut_addr,
  input  logic [DW-1:0]        lut_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        y,
  output logic                 sat,
  output logic [2:0]           dbg_state
);

  localparam int AW = 2*DW + $clog2(N_IN);
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CW = (LUT_LAT > 0) ? $clog2(LUT_LAT + 1) : 1;
  localparam int LW = ((DW > ADDR_W) ? DW : ADDR_W) + 2;

  localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);
  localparam logic [CW-1:0] ACT_WAIT = CW'((ACT_MODE == 1) ? 0 : LUT_LAT);

  localparam logic signed [AW:0] PRE_MAX = {{(AW+2-DW){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW:0] PRE_MIN = {{(AW+2-DW){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [LW-1:0] ADDR_CTR = {{(LW-ADDR_W){1'b0}}, 1'b1, {(ADDR_W-1){1'b0}}};
  localparam logic signed [LW-1:0] ADDR_MAX = {{(LW-ADDR_W){1'b0}}, {ADDR_W{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MAC  = 3'd1,
    S_BIAS = 3'd2,
    S_ACT  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t                 r_state;
  logic signed [DW-1:0]   r_x [N_IN];
  logic signed [DW-1:0]   r_w [N_IN];
  logic signed [DW-1:0]   r_bias;
  logic [IW-1:0]          r_idx;
  logic [CW-1:0]          r_cnt;
  logic signed [AW-1:0]   r_acc;
  logic signed [DW-1:0]   r_pre;

  logic signed [2*DW-1:0] w_prod;
  logic signed [AW:0]     w_pre_full;
  logic                   w_clip_hi;
  logic                   w_clip_lo;
  logic signed [DW-1:0]   w_pre_sat;
  logic signed [DW-1:0]   w_shifted;
  logic signed [LW-1:0]   w_addr_full;
  logic [ADDR_W-1:0]      w_addr;

  assign w_prod = r_x[r_idx] * r_w[r_idx];

  // One extra bit over the accumulator so the bias add cannot wrap before clipping.
  assign w_pre_full = (AW+1)'(r_acc >>> FRAC) + (AW+1)'(r_bias);
  assign w_clip_hi  = (w_pre_full > PRE_MAX);
  assign w_clip_lo  = (w_pre_full < PRE_MIN);

  always_comb begin
    w_pre_sat = w_pre_full[DW-1:0];
    if (w_clip_hi) w_pre_sat = {1'b0, {(DW-1){1'b1}}};
    if (w_clip_lo) w_pre_sat = {1'b1, {(DW-1){1'b0}}};
  end

  // LUT is centred on address 2^(ADDR_W-1); out-of-range codes stick to the ends.
  assign w_shifted   = w_pre_sat >>> LUT_SHIFT;
  assign w_addr_full = LW'(w_shifted) + ADDR_CTR;

  always_comb begin
    w_addr = w_addr_full[ADDR_W-1:0];
    if (w_addr_full[LW-1])          w_addr = '0;
    else if (w_addr_full > ADDR_MAX) w_addr = '1;
  end

  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
      sat       <= 1'b0;
      lut_addr  <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_pre     <= '0;
      r_bias    <= '0;
      for (int i = 0; i < N_IN; i++) begin
        r_x[i] <= '0;
        r_w[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N_IN; i++) begin
              r_x[i] <= x[DW*i +: DW];
              r_w[i] <= w[DW*i +: DW];
            end
            r_bias   <= bias;
            r_acc    <= '0;
            r_idx    <= '0;
            in_ready <= 1'b0;
            r_state  <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + AW'(w_prod);
          if (r_idx == LAST_IDX) begin
            r_state <= S_BIAS;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_BIAS: begin
          r_pre    <= w_pre_sat;
          sat      <= w_clip_hi | w_clip_lo;
          lut_addr <= w_addr;
          r_cnt    <= '0;
          r_state  <= S_ACT;
        end
        S_ACT: begin
          // Linear mode exits on the first cycle; LUT mode waits out the ROM latency.
          if (r_cnt == ACT_WAIT) begin
            y         <= (ACT_MODE == 1) ? r_pre : lut_data;
            out_valid <= 1'b1;
            r_state   <= S_OUT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
